// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   RESET_PC_DEFAULT : fetch address loaded on reset
//   PC_STEP          : sequential fetch increment
//   INST_NOP         : canonical NOP encoding for downstream bubble insertion
//   ENTRY_W          : width of one buffered {pc, inst} entry
package inst_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam int          ENTRY_W          = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle for the fetch unit: instruction-memory read port, decode-side
// valid/ready output, execute-side redirect, and status.
//   master : the fetch unit (drives IMEM_PC, OUT_*, MISALIGN_ERR, FETCH_COUNT)
//   slave  : the surrounding environment (memory, decode, execute)
interface inst_fetch_unit_if;
    logic [31:0] IMEM_PC;
    logic [31:0] IMEM_INST;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_PC;
    logic [31:0] OUT_INST;
    logic        REDIRECT_VALID;
    logic [31:0] REDIRECT_PC;
    logic        MISALIGN_ERR;
    logic [31:0] FETCH_COUNT;

    modport master (
        output IMEM_PC, OUT_VALID, OUT_PC, OUT_INST, MISALIGN_ERR, FETCH_COUNT,
        input  IMEM_INST, OUT_READY, REDIRECT_VALID, REDIRECT_PC
    );

    modport slave (
        input  IMEM_PC, OUT_VALID, OUT_PC, OUT_INST, MISALIGN_ERR, FETCH_COUNT,
        output IMEM_INST, OUT_READY, REDIRECT_VALID, REDIRECT_PC
    );
endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO with asynchronous active-high reset and
// a synchronous flush. Push while full is accepted when a pop happens in the
// same cycle. Head data reads as zero when empty.
//   clk_i, rst_i   : clock, async reset
//   flush_i        : discard all entries at the next edge (wins over push)
//   push_i/data_i  : write request and data
//   pop_i          : remove head entry
//   data_o         : head entry (zero when empty)
//   empty_o/full_o : occupancy flags
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & ~flush_i & (~full_o | pop_ok);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: owns the fetch PC, drives the instruction-memory address,
// captures the same-cycle instruction word into a {pc, inst} FIFO and hands
// entries to decode over valid/ready. A redirect from execute flushes the
// FIFO and reloads the PC (word-aligned); a misaligned target sets a sticky
// error flag.
//   CLK, RST : clock, async active-high reset
//   bus      : inst_fetch_unit_if.master (IMEM, decode output, redirect, status)
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic CLK,
    input  logic RST,
    inst_fetch_unit_if.master bus
);
    logic [31:0]  fpc_q, fpc_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  fetch_count_q, fetch_count_d;

    logic         fifo_empty, fifo_full;
    logic         pop, enq;
    fetch_entry_t wr_entry, head_entry;

    assign pop = bus.OUT_VALID & bus.OUT_READY;
    // A redirect suppresses the enqueue: the word at fpc is on the wrong path.
    assign enq = ~bus.REDIRECT_VALID & (~fifo_full | pop);

    assign wr_entry.pc   = fpc_q;
    assign wr_entry.inst = bus.IMEM_INST;

    fetch_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .flush_i (bus.REDIRECT_VALID),
        .push_i  (enq),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        fpc_d         = fpc_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;
        if (bus.REDIRECT_VALID) begin
            fpc_d = align_pc(bus.REDIRECT_PC);
            if (is_misaligned(bus.REDIRECT_PC)) misalign_d = 1'b1;
        end else if (enq) begin
            fpc_d = fpc_q + PC_STEP;
        end
        // A handshake completing alongside a redirect still counts.
        if (pop) fetch_count_d = fetch_count_q + 32'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fpc_q         <= RESET_PC;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            fpc_q         <= fpc_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.IMEM_PC      = fpc_q;
    assign bus.OUT_VALID    = ~fifo_empty;
    assign bus.OUT_PC       = head_entry.pc;
    assign bus.OUT_INST     = head_entry.inst;
    assign bus.MISALIGN_ERR = misalign_q;
    assign bus.FETCH_COUNT  = fetch_count_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fails;

    inst_fetch_unit_if ifc ();

    inst_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc.master)
    );

    // Instruction memory: word = address ^ A5A5_0000, available same cycle.
    assign ifc.IMEM_INST = ifc.IMEM_PC ^ 32'hA5A5_0000;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        RST = 1'b1;
        ifc.OUT_READY      = 1'b1;
        ifc.REDIRECT_VALID = 1'b0;
        ifc.REDIRECT_PC    = 32'h0;

        // Reset values
        tick(); tick();
        chk("rst_valid",    {31'b0, ifc.OUT_VALID},    32'h0);
        chk("rst_imem_pc",  ifc.IMEM_PC,               32'h0);
        chk("rst_out_pc",   ifc.OUT_PC,                32'h0);
        chk("rst_out_inst", ifc.OUT_INST,              32'h0);
        chk("rst_count",    ifc.FETCH_COUNT,           32'h0);
        chk("rst_misalign", {31'b0, ifc.MISALIGN_ERR}, 32'h0);

        // Streaming with OUT_READY=1
        RST = 1'b0;
        tick();
        chk("s_valid0", {31'b0, ifc.OUT_VALID}, 32'h1);
        chk("s_pc0",    ifc.OUT_PC,   32'h0000_0000);
        chk("s_inst0",  ifc.OUT_INST, 32'hA5A5_0000);
        tick();
        chk("s_pc1",    ifc.OUT_PC,   32'h0000_0004);
        chk("s_inst1",  ifc.OUT_INST, 32'hA5A5_0004);
        tick();
        chk("s_pc2",    ifc.OUT_PC,   32'h0000_0008);
        tick();
        chk("s_pc3",    ifc.OUT_PC,   32'h0000_000C);
        chk("s_inst3",  ifc.OUT_INST, 32'hA5A5_000C);
        tick();
        chk("s_count4", ifc.FETCH_COUNT, 32'd4);

        // Backpressure after a fresh reset
        RST = 1'b1;
        ifc.OUT_READY = 1'b0;
        #1;
        chk("bp_rst_valid", {31'b0, ifc.OUT_VALID}, 32'h0);
        tick();
        RST = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("bp_imem_pc", ifc.IMEM_PC, 32'h0000_0008);
        chk("bp_out_pc",  ifc.OUT_PC,  32'h0000_0000);
        chk("bp_valid",   {31'b0, ifc.OUT_VALID}, 32'h1);
        chk("bp_count",   ifc.FETCH_COUNT, 32'd0);
        ifc.OUT_READY = 1'b1;
        tick();
        chk("bp_rel_pc4", ifc.OUT_PC, 32'h0000_0004);
        tick();
        chk("bp_rel_pc8", ifc.OUT_PC, 32'h0000_0008);
        tick();
        chk("bp_rel_pc12", ifc.OUT_PC, 32'h0000_000C);
        chk("bp_rel_count", ifc.FETCH_COUNT, 32'd3);

        // Redirect while full and popping
        ifc.OUT_READY = 1'b0;
        tick();
        chk("rd_full_pc",   ifc.OUT_PC,  32'h0000_000C);
        chk("rd_full_imem", ifc.IMEM_PC, 32'h0000_0014);
        ifc.OUT_READY      = 1'b1;
        ifc.REDIRECT_VALID = 1'b1;
        ifc.REDIRECT_PC    = 32'h0000_0100;
        tick();
        ifc.REDIRECT_VALID = 1'b0;
        chk("rd_valid0", {31'b0, ifc.OUT_VALID}, 32'h0);
        chk("rd_count",  ifc.FETCH_COUNT, 32'd4);
        chk("rd_imem",   ifc.IMEM_PC, 32'h0000_0100);
        chk("rd_out_pc_zero", ifc.OUT_PC, 32'h0);
        tick();
        chk("rd_valid1", {31'b0, ifc.OUT_VALID}, 32'h1);
        chk("rd_pc100",  ifc.OUT_PC, 32'h0000_0100);
        chk("rd_inst100", ifc.OUT_INST, 32'hA5A5_0100);
        tick();
        chk("rd_pc104",  ifc.OUT_PC, 32'h0000_0104);
        chk("rd_misalign0", {31'b0, ifc.MISALIGN_ERR}, 32'h0);

        // Misaligned redirect
        ifc.REDIRECT_VALID = 1'b1;
        ifc.REDIRECT_PC    = 32'h0000_0203;
        tick();
        ifc.REDIRECT_VALID = 1'b0;
        chk("mis_err",   {31'b0, ifc.MISALIGN_ERR}, 32'h1);
        chk("mis_valid", {31'b0, ifc.OUT_VALID}, 32'h0);
        chk("mis_imem",  ifc.IMEM_PC, 32'h0000_0200);
        tick();
        chk("mis_pc200", ifc.OUT_PC, 32'h0000_0200);
        chk("mis_count", ifc.FETCH_COUNT, 32'd6);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("mis_sticky", {31'b0, ifc.MISALIGN_ERR}, 32'h1);
        end
        chk("mis_pc228", ifc.OUT_PC, 32'h0000_0228);

        // Aligned redirect near the top of the address space
        ifc.REDIRECT_VALID = 1'b1;
        ifc.REDIRECT_PC    = 32'hFFFF_FFF8;
        tick();
        ifc.REDIRECT_VALID = 1'b0;
        chk("wrap_err_kept", {31'b0, ifc.MISALIGN_ERR}, 32'h1);
        chk("wrap_valid0",   {31'b0, ifc.OUT_VALID}, 32'h0);
        tick();
        chk("wrap_pc_f8", ifc.OUT_PC, 32'hFFFF_FFF8);
        tick();
        chk("wrap_pc_fc", ifc.OUT_PC, 32'hFFFF_FFFC);
        chk("wrap_inst_fc", ifc.OUT_INST, 32'h5A5A_FFFC);
        tick();
        chk("wrap_pc_0", ifc.OUT_PC, 32'h0000_0000);
        tick();
        chk("wrap_pc_4", ifc.OUT_PC, 32'h0000_0004);
        chk("wrap_count", ifc.FETCH_COUNT, 32'd20);

        // Asynchronous reset with two entries buffered
        ifc.OUT_READY = 1'b0;
        tick();
        chk("ar_valid_pre", {31'b0, ifc.OUT_VALID}, 32'h1);
        chk("ar_imem_pre",  ifc.IMEM_PC, 32'h0000_000C);
        chk("ar_pc_pre",    ifc.OUT_PC,  32'h0000_0004);
        #2;
        RST = 1'b1;
        #1;
        chk("ar_valid",    {31'b0, ifc.OUT_VALID}, 32'h0);
        chk("ar_imem",     ifc.IMEM_PC, 32'h0);
        chk("ar_count",    ifc.FETCH_COUNT, 32'h0);
        chk("ar_out_pc",   ifc.OUT_PC, 32'h0);
        chk("ar_misalign", {31'b0, ifc.MISALIGN_ERR}, 32'h0);
        tick();
        RST = 1'b0;
        ifc.OUT_READY = 1'b1;
        tick();
        chk("ar_restart_valid", {31'b0, ifc.OUT_VALID}, 32'h1);
        chk("ar_restart_pc0",   ifc.OUT_PC, 32'h0);
        tick();
        chk("ar_restart_pc4",   ifc.OUT_PC, 32'h4);
        chk("ar_restart_count", ifc.FETCH_COUNT, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
